// File: rtl/hazard_sequencer_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_sequencer_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } md_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int unsigned MD_LATENCY_DEFAULT = 4;

  // True when x is a non-zero register actually read by the ID instruction.
  function automatic logic src_match(input logic [4:0] x,
                                     input logic [4:0] rs, input logic uses_rs,
                                     input logic [4:0] rt, input logic uses_rt);
    return (x != REG_ZERO) && ((uses_rs && (x == rs)) || (uses_rt && (x == rt)));
  endfunction

endpackage

// File: rtl/hazard_sequencer_if.sv
// Pipeline-side hazard inputs and fetch/decode control outputs.
interface hazard_sequencer_if;
  logic [4:0] ID_Rs;
  logic [4:0] ID_Rt;
  logic       ID_UsesRs;
  logic       ID_UsesRt;
  logic       ID_Branch;
  logic       ID_BranchTaken;
  logic       ID_MDStart;
  logic       ID_UsesHiLo;
  logic       IDEX_MemRead;
  logic       IDEX_RegWrite;
  logic [4:0] IDEX_Dest;
  logic       EXMEM_MemRead;
  logic [4:0] EXMEM_Dest;
  logic       PCWrite;
  logic       IFIDWrite;
  logic       IF_Flush;
  logic       IDEX_Bubble;
  logic       MD_Busy;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_Branch, ID_BranchTaken, ID_MDStart,
           ID_UsesHiLo, IDEX_MemRead, IDEX_RegWrite, IDEX_Dest, EXMEM_MemRead, EXMEM_Dest,
    input  PCWrite, IFIDWrite, IF_Flush, IDEX_Bubble, MD_Busy
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_Branch, ID_BranchTaken, ID_MDStart,
           ID_UsesHiLo, IDEX_MemRead, IDEX_RegWrite, IDEX_Dest, EXMEM_MemRead, EXMEM_Dest,
    output PCWrite, IFIDWrite, IF_Flush, IDEX_Bubble, MD_Busy
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Hazard controller: load-use, branch-operand and HI/LO stalls, branch flush, perf counters.
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter int unsigned MD_LATENCY = MD_LATENCY_DEFAULT,
  parameter int unsigned CNT_W      = 32
) (
  input  logic               Clk,
  input  logic               Reset_n,
  hazard_sequencer_if.slave  hz,
  output logic [CNT_W-1:0]   StallCycles,
  output logic [CNT_W-1:0]   FlushCount
);

  localparam int unsigned MdCntW = $clog2(MD_LATENCY + 1);
  localparam logic [MdCntW-1:0] MdLoad = MdCntW'(MD_LATENCY);

  md_state_e         state_q, state_d;
  logic [MdCntW-1:0] md_cnt_q, md_cnt_d;

  logic load_use, br_alu, br_load, hilo, stall;
  logic pc_write, ifid_write, if_flush, idex_bubble;

  always_comb begin
    load_use = hz.IDEX_MemRead &&
               src_match(hz.IDEX_Dest, hz.ID_Rs, hz.ID_UsesRs, hz.ID_Rt, hz.ID_UsesRt);
    br_alu   = hz.ID_Branch && hz.IDEX_RegWrite &&
               src_match(hz.IDEX_Dest, hz.ID_Rs, hz.ID_UsesRs, hz.ID_Rt, hz.ID_UsesRt);
    br_load  = hz.ID_Branch && hz.EXMEM_MemRead &&
               src_match(hz.EXMEM_Dest, hz.ID_Rs, hz.ID_UsesRs, hz.ID_Rt, hz.ID_UsesRt);
    hilo     = (state_q == MD_WAIT) && hz.ID_UsesHiLo;
    stall    = load_use || br_alu || br_load || hilo;
  end

  // Stall wins over flush: the branch has not resolved while it is held in ID.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    if_flush    = 1'b0;
    idex_bubble = 1'b0;
    if (!Reset_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (hz.ID_BranchTaken) begin
      if_flush = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      RUN: begin
        if (hz.ID_MDStart && !stall) begin
          state_d  = MD_WAIT;
          md_cnt_d = MdLoad;
        end
      end
      MD_WAIT: begin
        if (md_cnt_q <= MdCntW'(1)) begin
          state_d  = RUN;
          md_cnt_d = '0;
        end else begin
          md_cnt_d = md_cnt_q - MdCntW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  assign hz.PCWrite     = pc_write;
  assign hz.IFIDWrite   = ifid_write;
  assign hz.IF_Flush    = if_flush;
  assign hz.IDEX_Bubble = idex_bubble;
  assign hz.MD_Busy     = Reset_n && (state_q == MD_WAIT);

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .inc     (stall && Reset_n),
    .count   (StallCycles)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .inc     (if_flush),
    .count   (FlushCount)
  );

endmodule
